// File: rtl/maxheap_feeder.sv
// maxheap_feeder: turns a framed signed sample stream into (index, |sample|) entries for the top-N heap.
// Optional build macro MAXHEAP_FEEDER_THRESH_EN adds a 'thresh' port that suppresses small magnitudes.
module maxheap_feeder #(
  parameter int DATA_WIDTH   = 10,
  parameter int PRIO_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 1024
) (
  input  logic                    sink_clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_sample,
  input  logic                    in_sof,
  output logic                    src_valid,
  output logic [DATA_WIDTH-1:0]   src_data,
  output logic [PRIO_WIDTH-1:0]   src_prio,
  output logic                    heap_clear,
  output logic                    frame_done,
  output logic                    sof_err,
  output logic [15:0]             drop_cnt
`ifdef MAXHEAP_FEEDER_THRESH_EN
  ,
  input  logic [PRIO_WIDTH-1:0]   thresh
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(FRAME_LEN - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   idx_q, idx_d;
  logic                    src_valid_q, src_valid_d;
  logic [DATA_WIDTH-1:0]   src_data_q, src_data_d;
  logic [PRIO_WIDTH-1:0]   src_prio_q, src_prio_d;
  logic                    sof_err_q, sof_err_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic                    run_beat;
  logic                    fwd;
  logic [SAMPLE_WIDTH:0]   sample_ext;
  logic [SAMPLE_WIDTH:0]   mag;
  logic [PRIO_WIDTH-1:0]   prio;

  // One extra bit lets the most negative sample map to its exact magnitude.
  always_comb begin
    sample_ext = {in_sample[SAMPLE_WIDTH-1], in_sample};
    mag        = sample_ext[SAMPLE_WIDTH] ? (~sample_ext + (SAMPLE_WIDTH+1)'(1)) : sample_ext;
    prio       = PRIO_WIDTH'(mag);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sof_err_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;
    in_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~in_sof;
        if (in_valid && !in_sof && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        if (in_valid && in_sof) state_d = CLEAR;
      end
      CLEAR: begin
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // A sof at idx 0 is the legitimate first sample; anywhere else it aborts the frame.
        in_ready = ~(in_sof && idx_q != '0);
        if (in_valid && in_ready) begin
          idx_d = idx_q + DATA_WIDTH'(1);
          if (idx_q == LAST_IDX) state_d = DONE;
        end else if (in_valid && in_sof && idx_q != '0) begin
          sof_err_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run_beat = in_valid && in_ready && (state_q == RUN);

  always_comb begin
    fwd = run_beat;
`ifdef MAXHEAP_FEEDER_THRESH_EN
    fwd = run_beat && (prio > thresh);
`endif
    src_valid_d = fwd;
    src_data_d  = fwd ? idx_q : src_data_q;
    src_prio_d  = fwd ? prio  : src_prio_q;
  end

  always_ff @(posedge sink_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      src_valid_q <= 1'b0;
      src_data_q  <= '0;
      src_prio_q  <= '0;
      sof_err_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_valid_q <= src_valid_d;
      src_data_q  <= src_data_d;
      src_prio_q  <= src_prio_d;
      sof_err_q   <= sof_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign src_valid  = src_valid_q;
  assign src_data   = src_data_q;
  assign src_prio   = src_prio_q;
  assign sof_err    = sof_err_q;
  assign drop_cnt   = drop_cnt_q;
  assign heap_clear = (state_q == CLEAR);
  assign frame_done = (state_q == DONE);

endmodule
